// File: rtl/gather_pkg.sv
// Shared definitions for the gold_ring gather scheduler: packet layout,
// FSM states, error-code bits and the per-pair routing header.
package gather_pkg;

    localparam int unsigned NODES   = 4;

    localparam int unsigned VC_B    = 63;
    localparam int unsigned DIR_B   = 62;
    localparam int unsigned HOP_MSB = 55;
    localparam int unsigned HOP_LSB = 48;
    localparam int unsigned SRC_MSB = 47;
    localparam int unsigned SRC_LSB = 32;
    localparam int unsigned PAY_MSB = 31;
    localparam int unsigned PAY_LSB = 0;

    localparam int unsigned ERR_TIMEOUT  = 0;
    localparam int unsigned ERR_MISROUTE = 1;
    localparam int unsigned ERR_BADPKT   = 2;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_RUN,
        ST_PEND,
        ST_DONE,
        ST_ERROR
    } state_t;

    // Returns {dir, hop}: one or two hops clockwise, or one hop counter-clockwise.
    function automatic logic [8:0] route(input logic [1:0] src, input logic [1:0] dst);
        logic [1:0] d;
        d = dst - src;
        case (d)
            2'd1:    route = {1'b0, 8'h01};
            2'd2:    route = {1'b0, 8'h03};
            2'd3:    route = {1'b1, 8'h01};
            default: route = '0;
        endcase
    endfunction

endpackage

// File: rtl/gather_node_port.sv
// One ring node's injection side: builds the gather packet for the current
// phase, gates injection on readiness and polarity, and remembers it has sent.
module gather_node_port
    import gather_pkg::*;
#(
    parameter logic [1:0] NODE_ID = 2'd0
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        clear,
    input  logic        run,
    input  logic [1:0]  cur_phase,
    input  logic        polarity,
    input  logic        peri,
    output logic        pesi,
    output logic [63:0] pedi,
    output logic        sent
);

    logic        sent_q, sent_d;
    logic [8:0]  rt;
    logic [63:0] pkt;

    always_comb begin
        rt                   = route(NODE_ID, cur_phase);
        pkt                  = '0;
        pkt[VC_B]            = 1'b0;
        pkt[DIR_B]           = rt[8];
        pkt[HOP_MSB:HOP_LSB] = rt[7:0];
        pkt[SRC_MSB:SRC_LSB] = 16'(NODE_ID);
        pkt[PAY_MSB:PAY_LSB] = 32'(cur_phase);

        // Polarity 0 opens nodes 0/1, polarity 1 opens nodes 2/3.
        pesi = run && (NODE_ID != cur_phase) && !sent_q && peri && (polarity == NODE_ID[1]);
        pedi = pesi ? pkt : '0;

        sent_d = sent_q;
        if (clear) begin
            sent_d = 1'b0;
        end else if (pesi) begin
            sent_d = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            sent_q <= 1'b0;
        end else begin
            sent_q <= sent_d;
        end
    end

    assign sent = sent_q;

endmodule

// File: rtl/gather_scheduler.sv
// Runs back-to-back gather rounds on the 4-node gold_ring: in phase p every
// other node sends one packet to node p, deliveries are checked, latency kept.
module gather_scheduler
    import gather_pkg::*;
#(
    parameter int unsigned ROUNDS  = 7,
    parameter int unsigned TIMEOUT = 1024,
    parameter int unsigned LAT_W   = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic             polarity,
    input  logic [3:0]       peri,
    output logic [3:0]       pesi,
    output logic [255:0]     pedi,
    output logic [3:0]       pero,
    input  logic [3:0]       peso,
    input  logic [255:0]     pedo,
    output logic             busy,
    output logic             done,
    output logic             err,
    output logic [2:0]       err_code,
    output logic [1:0]       cur_phase,
    output logic [7:0]       cur_round,
    output logic             phase_done,
    output logic [LAT_W-1:0] phase_lat
);

    state_t             state_q, state_d;
    logic [1:0]         phase_q, phase_d;
    logic [7:0]         round_q, round_d;
    logic [2:0]         err_q, err_d;
    logic [LAT_W-1:0]   cnt_q, cnt_d;
    logic [LAT_W-1:0]   lat_q, lat_d;
    logic [NODES-1:0]   recv_q, recv_d;
    logic [NODES-1:0]   sent, sent_next, dest_mask;
    logic               run, clear, start_ok, complete;
    logic [15:0]        src;
    logic [31:0]        pay;
    logic               unused_hdr;

    for (genvar g = 0; g < NODES; g++) begin : g_port
        gather_node_port #(
            .NODE_ID(2'(g))
        ) u_port (
            .clk      (clk),
            .reset    (reset),
            .clear    (clear),
            .run      (run),
            .cur_phase(phase_q),
            .polarity (polarity),
            .peri     (peri[g]),
            .pesi     (pesi[g]),
            .pedi     (pedi[64*g +: 64]),
            .sent     (sent[g])
        );
    end

    always_comb begin
        state_d    = state_q;
        phase_d    = phase_q;
        round_d    = round_q;
        err_d      = err_q;
        cnt_d      = cnt_q;
        lat_d      = lat_q;
        recv_d     = recv_q;
        complete   = 1'b0;
        src        = '0;
        pay        = '0;
        unused_hdr = 1'b0;

        start_ok  = start && (state_q inside {ST_IDLE, ST_DONE, ST_ERROR});
        run       = (state_q == ST_RUN);
        clear     = start_ok || (state_q == ST_PEND);
        dest_mask = '0;
        dest_mask[phase_q] = 1'b1;
        sent_next = sent | pesi;

        case (state_q)
            ST_IDLE, ST_DONE, ST_ERROR: begin
                if (start_ok) begin
                    state_d = ST_RUN;
                    phase_d = '0;
                    round_d = '0;
                    err_d   = '0;
                    cnt_d   = '0;
                    recv_d  = '0;
                end
            end
            ST_RUN: begin
                if (cnt_q != '1) begin
                    cnt_d = cnt_q + 1'b1;
                end
                for (int unsigned n = 0; n < NODES; n++) begin
                    // Routing header is not checked at the destination.
                    unused_hdr = unused_hdr ^ (^pedo[64*n+HOP_LSB +: 16]);
                    if (peso[n]) begin
                        if (n != 32'(phase_q)) begin
                            err_d[ERR_MISROUTE] = 1'b1;
                        end else begin
                            src = pedo[64*n+SRC_LSB +: 16];
                            pay = pedo[64*n+PAY_LSB +: 32];
                            if (src != 16'(phase_q) && src < 16'(NODES) &&
                                pay == 32'(phase_q) && !recv_q[src[1:0]]) begin
                                recv_d[src[1:0]] = 1'b1;
                            end else begin
                                err_d[ERR_BADPKT] = 1'b1;
                            end
                        end
                    end
                end
                if (cnt_d >= LAT_W'(TIMEOUT)) begin
                    err_d[ERR_TIMEOUT] = 1'b1;
                end
                // Same-cycle injections and deliveries both count toward completion.
                complete = ((sent_next | dest_mask) == '1) && ((recv_d | dest_mask) == '1);
                if (err_d != '0) begin
                    state_d = ST_ERROR;
                end else if (complete) begin
                    state_d = ST_PEND;
                    lat_d   = cnt_q;
                end
            end
            ST_PEND: begin
                cnt_d   = '0;
                recv_d  = '0;
                phase_d = phase_q + 2'd1;
                if (phase_q == 2'd3) begin
                    round_d = round_q + 8'd1;
                end
                if (round_q == 8'(ROUNDS - 1) && phase_q == 2'd3) begin
                    state_d = ST_DONE;
                end else begin
                    state_d = ST_RUN;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q <= ST_IDLE;
            phase_q <= '0;
            round_q <= '0;
            err_q   <= '0;
            cnt_q   <= '0;
            lat_q   <= '0;
            recv_q  <= '0;
        end else begin
            state_q <= state_d;
            phase_q <= phase_d;
            round_q <= round_d;
            err_q   <= err_d;
            cnt_q   <= cnt_d;
            lat_q   <= lat_d;
            recv_q  <= recv_d;
        end
    end

    assign pero       = run ? '1 : '0;
    assign busy       = run || (state_q == ST_PEND);
    assign done       = (state_q == ST_DONE);
    assign err        = (state_q == ST_ERROR);
    assign err_code   = err_q;
    assign cur_phase  = phase_q;
    assign cur_round  = round_q;
    assign phase_done = (state_q == ST_PEND);
    assign phase_lat  = lat_q;

endmodule

// File: tb/tb_gather_scheduler.sv
// Bench for gather_scheduler: ideal ring model plus scoreboard on phase_done,
// and directed polarity, misroute, duplicate, timeout and reset scenarios.
module tb_gather_scheduler;

    localparam int unsigned ROUNDS  = 7;
    localparam int unsigned TIMEOUT = 64;
    localparam int unsigned LAT_W   = 16;

    typedef struct packed {
        logic [1:0] phase;
        logic [7:0] round;
    } pd_t;

    logic             clk, reset, start, polarity;
    logic [3:0]       peri, pesi, pero, peso;
    logic [255:0]     pedi, pedo;
    logic             busy, done, err, phase_done;
    logic [2:0]       err_code;
    logic [1:0]       cur_phase;
    logic [7:0]       cur_round;
    logic [LAT_W-1:0] phase_lat;

    logic             pol_s, pol_t, tog_en, model_en, drop_req;
    logic [3:0]       m_peso, s_peso;
    logic [255:0]     m_pedo, s_pedo;

    int unsigned cyc = 0;
    int          n_checks = 0;
    int          n_fail = 0;
    int unsigned n_pd = 0;
    int unsigned last_deliv = 0;
    int unsigned entry_cyc = 0;
    logic [1:0]  exp_phase = 2'd0;
    pd_t         exp_q[$];

    assign peso     = m_peso | s_peso;
    assign pedo     = m_pedo | s_pedo;
    assign polarity = tog_en ? pol_t : pol_s;

    gather_scheduler #(
        .ROUNDS (ROUNDS),
        .TIMEOUT(TIMEOUT),
        .LAT_W  (LAT_W)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .start     (start),
        .polarity  (polarity),
        .peri      (peri),
        .pesi      (pesi),
        .pedi      (pedi),
        .pero      (pero),
        .peso      (peso),
        .pedo      (pedo),
        .busy      (busy),
        .done      (done),
        .err       (err),
        .err_code  (err_code),
        .cur_phase (cur_phase),
        .cur_round (cur_round),
        .phase_done(phase_done),
        .phase_lat (phase_lat)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial pol_t = 1'b0;
    always @(posedge clk) begin
        cyc   <= cyc + 1;
        pol_t <= ~pol_t;
    end

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Hand-derived upper packet words {vc,dir,res,hop,src} for each (dst,src).
    function automatic logic [31:0] exp_hi(input logic [1:0] dst, input logic [1:0] src);
        case ({dst, src})
            4'h1:    exp_hi = 32'h4001_0001;
            4'h2:    exp_hi = 32'h0003_0002;
            4'h3:    exp_hi = 32'h0001_0003;
            4'h4:    exp_hi = 32'h0001_0000;
            4'h6:    exp_hi = 32'h4001_0002;
            4'h7:    exp_hi = 32'h0003_0003;
            4'h8:    exp_hi = 32'h0003_0000;
            4'h9:    exp_hi = 32'h0001_0001;
            4'hB:    exp_hi = 32'h4001_0003;
            4'hC:    exp_hi = 32'h4001_0000;
            4'hD:    exp_hi = 32'h0003_0001;
            4'hE:    exp_hi = 32'h0001_0002;
            default: exp_hi = 32'hDEAD_DEAD;
        endcase
    endfunction

    // Ideal ring: 3 cycles per hop, one delivery per cycle at the destination.
    initial begin : ring_model
        logic [63:0] pkt;
        logic [1:0]  d;
        int unsigned hops;
        logic [63:0] q_pkt[$];
        int unsigned q_t[$];
        logic [1:0]  q_dst[$];
        bit          dropped;
        dropped = 1'b0;
        m_peso  = '0;
        m_pedo  = '0;
        forever begin
            @(negedge clk);
            m_peso = '0;
            m_pedo = '0;
            if (!model_en) begin
                q_pkt.delete();
                q_t.delete();
                q_dst.delete();
            end else begin
                for (int n = 0; n < 4; n++) begin
                    if (pesi[n]) begin
                        pkt = pedi[64*n +: 64];
                        chk("inj_pkt", pkt, {exp_hi(exp_phase, 2'(n)), 30'd0, exp_phase});
                        if (exp_phase == 2'd2 && n == 3) chk("ph2_node3_pkt", pkt, 64'h4001_0003_0000_0002);
                        if (exp_phase == 2'd2 && n == 0) chk("ph2_node0_pkt", pkt, 64'h0003_0000_0000_0002);
                        d    = exp_phase - 2'(n);
                        hops = (d == 2'd3) ? 1 : int'(d);
                        if (drop_req && !dropped) begin
                            dropped = 1'b1;
                        end else begin
                            q_pkt.push_back(pkt);
                            q_t.push_back(cyc + 3 * hops);
                            q_dst.push_back(exp_phase);
                        end
                    end
                end
                for (int i = 0; i < q_t.size(); i++) begin
                    if (q_t[i] <= cyc) begin
                        m_peso[q_dst[i]]             = 1'b1;
                        m_pedo[64*q_dst[i] +: 64]    = q_pkt[i];
                        last_deliv                   = cyc;
                        q_pkt.delete(i);
                        q_t.delete(i);
                        q_dst.delete(i);
                        break;
                    end
                end
            end
        end
    end

    // Scoreboard monitor: every phase_done pulse must match the next expectation.
    initial begin : monitor
        pd_t  e;
        logic prev_busy, prev_pd;
        prev_busy = 1'b0;
        prev_pd   = 1'b0;
        forever begin
            @(negedge clk);
            if (!busy) exp_phase = 2'd0;
            if (busy && !phase_done && (!prev_busy || prev_pd)) entry_cyc = cyc;
            if (phase_done) begin
                n_pd++;
                chk("pd_expected", 64'(exp_q.size() != 0), 64'd1);
                if (exp_q.size() != 0) begin
                    e = exp_q.pop_front();
                    chk("pd_phase", 64'(cur_phase), 64'(e.phase));
                    chk("pd_round", 64'(cur_round), 64'(e.round));
                    chk("pd_lat", 64'(phase_lat), 64'(last_deliv - entry_cyc));
                end
                exp_phase = exp_phase + 2'd1;
            end
            prev_busy = busy;
            prev_pd   = phase_done;
        end
    end

    initial begin
        #400000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check_reset_outputs(input string tag);
        chk({tag, "_flags"}, 64'({busy, done, err, err_code, phase_done}), 64'd0);
        chk({tag, "_pos"}, 64'({cur_phase, cur_round}), 64'd0);
        chk({tag, "_lat"}, 64'(phase_lat), 64'd0);
        chk({tag, "_pe"}, 64'({pesi, pero}), 64'd0);
        chk({tag, "_pedi"}, 64'(pedi != '0), 64'd0);
    endtask

    task automatic pulse_start();
        @(negedge clk) start = 1'b1;
        @(negedge clk) start = 1'b0;
    endtask

    initial begin
        pd_t         e;
        logic [3:0]  bad;
        int unsigned pd0;
        reset    = 1'b0;
        start    = 1'b0;
        peri     = 4'hF;
        pol_s    = 1'b0;
        tog_en   = 1'b0;
        model_en = 1'b0;
        drop_req = 1'b0;
        s_peso   = '0;
        s_pedo   = '0;
        repeat (3) @(negedge clk);
        check_reset_outputs("rst");
        reset = 1'b1;

        // Full run on the ideal ring with polarity toggling every cycle.
        for (int r = 0; r < int'(ROUNDS); r++) begin
            for (int p = 0; p < 4; p++) begin
                e.phase = 2'(p);
                e.round = 8'(r);
                exp_q.push_back(e);
            end
        end
        tog_en   = 1'b1;
        model_en = 1'b1;
        pd0      = n_pd;
        pulse_start();
        for (int k = 0; k < 3000 && !done; k++) @(negedge clk);
        chk("A_done", 64'(done), 64'd1);
        chk("A_err", 64'(err), 64'd0);
        chk("A_round", 64'(cur_round), 64'd7);
        chk("A_npd", 64'(n_pd - pd0), 64'd28);
        chk("A_sb_empty", 64'(exp_q.size()), 64'd0);

        // Polarity held 0 in phase 0: only node 1 may inject.
        tog_en   = 1'b0;
        model_en = 1'b0;
        pol_s    = 1'b0;
        pulse_start();
        chk("B_first_pesi", 64'(pesi), 64'h2);
        bad = '0;
        repeat (19) begin
            @(negedge clk);
            bad = bad | pesi;
        end
        chk("B_hold_pesi", 64'(bad), 64'd0);
        pol_s = 1'b1;
        #1;
        chk("B_pol1_pesi", 64'(pesi), 64'hC);
        @(negedge clk);
        chk("B_after_pesi", 64'(pesi), 64'd0);

        // Delivery at node 1 while node 0 is the destination.
        s_peso          = 4'b0010;
        s_pedo[127:64]  = 64'h0001_0000_0000_0000;
        @(negedge clk);
        chk("B_err", 64'(err), 64'd1);
        chk("B_code", 64'(err_code), 64'h2);
        chk("B_pesi_err", 64'(pesi), 64'd0);
        chk("B_pero_err", 64'(pero), 64'd0);
        @(negedge clk);
        chk("B_code_held", 64'(err_code), 64'h2);
        s_peso = '0;
        s_pedo = '0;
        pulse_start();
        chk("B_rearm_err", 64'(err), 64'd0);
        chk("B_rearm_code", 64'(err_code), 64'd0);
        chk("B_rearm_busy", 64'(busy), 64'd1);
        chk("B_rearm_pesi", 64'(pesi), 64'hC);

        // Duplicate delivery from source 2 at node 0.
        s_peso        = 4'b0001;
        s_pedo[63:0]  = 64'h0003_0002_0000_0000;
        @(negedge clk);
        chk("D_first_ok", 64'(err), 64'd0);
        @(negedge clk);
        s_peso = '0;
        s_pedo = '0;
        chk("D_dup_err", 64'(err), 64'd1);
        chk("D_dup_code", 64'(err_code), 64'h4);

        // Ring drops one packet: timeout after 64 cycles in the phase.
        tog_en   = 1'b1;
        model_en = 1'b1;
        drop_req = 1'b1;
        pulse_start();
        repeat (63) @(negedge clk);
        chk("E_pre_timeout", 64'(err), 64'd0);
        @(negedge clk);
        chk("E_timeout_err", 64'(err), 64'd1);
        chk("E_timeout_code", 64'(err_code), 64'h1);
        chk("E_timeout_pesi", 64'(pesi), 64'd0);

        // Reset in the middle of a phase.
        pulse_start();
        repeat (4) @(negedge clk);
        chk("R_busy_before", 64'(busy), 64'd1);
        reset    = 1'b0;
        model_en = 1'b0;
        @(negedge clk);
        check_reset_outputs("R");
        reset = 1'b1;
        @(negedge clk);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
